// File: rtl/edn_resp_pkg.sv
// Shared types and defaults for the EDN endpoint responder.
package edn_resp_pkg;

  localparam int unsigned DefaultBusWidth     = 32;
  localparam int unsigned DefaultGenBitsWidth = 128;

  // Sparse encoding: every pair of valid states differs in at least 3 bits.
  typedef enum logic [4:0] {
    StDisabled = 5'b01110,
    StEmpty    = 5'b10011,
    StFull     = 5'b11101
  } resp_state_e;

endpackage

// File: rtl/edn_endpoint_resp.sv
// EDN endpoint responder: buffers one genbits word and serves it as bus-width beats,
// little end first, scrubbing the buffer on disable or reset.
module edn_endpoint_resp
  import edn_resp_pkg::*;
#(
  parameter int unsigned BusWidth     = DefaultBusWidth,
  parameter int unsigned GenBitsWidth = DefaultGenBitsWidth,
  parameter int unsigned CntWidth     = 16
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    enable_i,
  input  logic                    edn_req_i,
  output logic                    edn_ack_o,
  output logic [BusWidth-1:0]     edn_bus_o,
  output logic                    edn_fips_o,
  input  logic                    genbits_valid_i,
  output logic                    genbits_ready_o,
  input  logic [GenBitsWidth-1:0] genbits_bus_i,
  input  logic                    genbits_fips_i,
  output logic [CntWidth-1:0]     beats_served_o,
  output logic                    idle_o
);

  localparam int unsigned NumBeats = GenBitsWidth / BusWidth;
  localparam int unsigned BeatW    = (NumBeats > 1) ? $clog2(NumBeats) : 1;

  resp_state_e             state_q, state_d;
  logic [GenBitsWidth-1:0] word_q, word_d;
  logic                    fips_q, fips_d;
  logic [BeatW-1:0]        beat_q, beat_d;
  logic [CntWidth-1:0]     cnt_q, cnt_d;
  logic                    ack;

  always_comb begin
    state_d = state_q;
    word_d  = word_q;
    fips_d  = fips_q;
    beat_d  = beat_q;
    cnt_d   = cnt_q;

    ack             = edn_req_i && enable_i && (state_q == StFull);
    genbits_ready_o = enable_i && (state_q == StEmpty);

    if (!enable_i) begin
      state_d = StDisabled;
      word_d  = '0;
      fips_d  = 1'b0;
      beat_d  = '0;
    end else begin
      case (state_q)
        StDisabled: state_d = StEmpty;
        StEmpty: begin
          if (genbits_valid_i) begin
            word_d  = genbits_bus_i;
            fips_d  = genbits_fips_i;
            beat_d  = '0;
            state_d = StFull;
          end
        end
        StFull: begin
          if (ack) begin
            if (beat_q == BeatW'(NumBeats - 1)) begin
              beat_d  = '0;
              word_d  = '0;
              fips_d  = 1'b0;
              state_d = StEmpty;
            end else begin
              beat_d = beat_q + BeatW'(1);
            end
          end
        end
        // Corrupted state register: fall back to a scrubbed, disabled endpoint.
        default: begin
          state_d = StDisabled;
          word_d  = '0;
          fips_d  = 1'b0;
          beat_d  = '0;
        end
      endcase
    end

    if (ack && (cnt_q != '1)) begin
      cnt_d = cnt_q + CntWidth'(1);
    end

    edn_ack_o      = ack;
    edn_bus_o      = ack ? word_q[BusWidth*int'(beat_q) +: BusWidth] : '0;
    edn_fips_o     = ack ? fips_q : 1'b0;
    beats_served_o = cnt_q;
    idle_o         = (state_q != StFull) && !edn_req_i;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= StDisabled;
      word_q  <= '0;
      fips_q  <= 1'b0;
      beat_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      word_q  <= word_d;
      fips_q  <= fips_d;
      beat_q  <= beat_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_edn_endpoint_resp.sv
// Self-checking bench for edn_endpoint_resp: directed table, corner sequences and random
// traffic against a queue-of-beats reference model.
module tb_edn_endpoint_resp;

  logic         clk = 1'b0;
  logic         rst_n, en, req, gv, gfips;
  logic [127:0] gbus;

  logic         ack, fips, ready, idle;
  logic [31:0]  bus;
  logic [15:0]  cnt;
  logic         ack4, fips4, ready4, idle4;
  logic [31:0]  bus4;
  logic [3:0]   cnt4;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  edn_endpoint_resp u_dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .enable_i       (en),
    .edn_req_i      (req),
    .edn_ack_o      (ack),
    .edn_bus_o      (bus),
    .edn_fips_o     (fips),
    .genbits_valid_i(gv),
    .genbits_ready_o(ready),
    .genbits_bus_i  (gbus),
    .genbits_fips_i (gfips),
    .beats_served_o (cnt),
    .idle_o         (idle)
  );

  edn_endpoint_resp #(
    .CntWidth(4)
  ) u_dut4 (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .enable_i       (en),
    .edn_req_i      (req),
    .edn_ack_o      (ack4),
    .edn_bus_o      (bus4),
    .edn_fips_o     (fips4),
    .genbits_valid_i(gv),
    .genbits_ready_o(ready4),
    .genbits_bus_i  (gbus),
    .genbits_fips_i (gfips),
    .beats_served_o (cnt4),
    .idle_o         (idle4)
  );

  // Reference model: pending beats as a queue; "armed" means at least one enabled cycle
  // has passed since the last disable or reset.
  typedef struct {
    logic [31:0] d;
    logic        f;
  } beat_t;

  beat_t       mq[$];
  bit          m_armed;
  int unsigned m_c16, m_c4;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic r, input logic e, input logic q, input logic v,
                       input logic [127:0] w, input logic f);
    rst_n = r;
    en    = e;
    req   = q;
    gv    = v;
    gbus  = w;
    gfips = f;
  endtask

  // Compare against the model for the current cycle, then advance one clock.
  task automatic step();
    bit          m_ack, m_ready;
    logic [31:0] m_bus;
    logic        m_fips;
    #1;
    m_ready = en && m_armed && (mq.size() == 0);
    m_ack   = req && en && (mq.size() != 0);
    m_bus   = m_ack ? mq[0].d : 32'h0;
    m_fips  = m_ack ? mq[0].f : 1'b0;
    chk("ack", ack, m_ack);
    chk("bus", bus, m_bus);
    chk("fips", fips, m_fips);
    chk("ready", ready, m_ready);
    chk("idle", idle, (mq.size() == 0) && !req);
    chk("cnt16", cnt, m_c16);
    chk("ack4", ack4, m_ack);
    chk("cnt4", cnt4, m_c4);
    @(posedge clk);
    if (!rst_n) begin
      m_armed = 0;
      mq.delete();
      m_c16 = 0;
      m_c4  = 0;
    end else begin
      if (m_ack) begin
        void'(mq.pop_front());
        if (m_c16 < 16'hffff) m_c16++;
        if (m_c4 < 4'hf) m_c4++;
      end
      if (!en) begin
        m_armed = 0;
        mq.delete();
      end else begin
        if (m_ready && gv) begin
          for (int k = 0; k < 4; k++) mq.push_back('{d: gbus[k*32 +: 32], f: gfips});
        end
        m_armed = 1;
      end
    end
    #1;
  endtask

  typedef struct {
    logic        rst_n, en, req, valid, fin;
    logic        e_ack;
    logic [31:0] e_bus;
    logic        e_fips, e_ready, e_idle;
  } vec_t;

  localparam logic [127:0] WordW = 128'h0f0e0d0c_0b0a0908_07060504_03020100;

  vec_t vecs[8];

  initial begin
    logic [127:0] wa, wb;

    vecs[0] = '{1, 0, 1, 0, 0, 0, 32'h0,        0, 0, 0};
    vecs[1] = '{1, 1, 0, 0, 0, 0, 32'h0,        0, 0, 1};
    vecs[2] = '{1, 1, 0, 1, 1, 0, 32'h0,        0, 1, 1};
    vecs[3] = '{1, 1, 1, 0, 0, 1, 32'h03020100, 1, 0, 0};
    vecs[4] = '{1, 1, 1, 0, 0, 1, 32'h07060504, 1, 0, 0};
    vecs[5] = '{1, 1, 1, 0, 0, 1, 32'h0b0a0908, 1, 0, 0};
    vecs[6] = '{1, 1, 1, 0, 0, 1, 32'h0f0e0d0c, 1, 0, 0};
    vecs[7] = '{1, 1, 1, 0, 0, 0, 32'h0,        0, 1, 0};

    drive(0, 0, 0, 0, '0, 0);
    repeat (2) @(posedge clk);
    #1;
    m_armed = 0;
    m_c16   = 0;
    m_c4    = 0;
    chk("rst_ack", ack, 0);
    chk("rst_bus", bus, 0);
    chk("rst_ready", ready, 0);
    chk("rst_cnt", cnt, 0);
    chk("rst_idle", idle, 1);

    // Basic word, table driven.
    for (int i = 0; i < 8; i++) begin
      drive(vecs[i].rst_n, vecs[i].en, vecs[i].req, vecs[i].valid, WordW, vecs[i].fin);
      #1;
      chk($sformatf("vec%0d_ack", i), ack, vecs[i].e_ack);
      chk($sformatf("vec%0d_bus", i), bus, vecs[i].e_bus);
      chk($sformatf("vec%0d_fips", i), fips, vecs[i].e_fips);
      chk($sformatf("vec%0d_ready", i), ready, vecs[i].e_ready);
      chk($sformatf("vec%0d_idle", i), idle, vecs[i].e_idle);
      step();
    end
    chk("basic_cnt", cnt, 4);

    // Back-pressure: held request with no upstream word.
    drive(1, 1, 1, 0, '0, 0);
    repeat (3) step();
    wa = {$urandom, $urandom, $urandom, $urandom};
    drive(1, 1, 1, 1, wa, 0);
    step();
    drive(1, 1, 1, 0, '0, 0);
    #1;
    chk("bp_first_ack", ack, 1);
    chk("bp_first_bus", bus, wa[31:0]);
    repeat (4) step();

    // Disable mid-word: two beats, one disabled cycle, then a fresh word.
    wa = {$urandom, $urandom, $urandom, $urandom};
    drive(1, 1, 0, 1, wa, 1);
    step();
    drive(1, 1, 1, 0, '0, 0);
    repeat (2) step();
    drive(1, 0, 1, 0, '0, 0);
    #1;
    chk("dis_no_ack", ack, 0);
    step();
    drive(1, 1, 1, 0, '0, 0);
    repeat (2) step();
    wb = {$urandom, $urandom, $urandom, $urandom};
    drive(1, 1, 1, 1, wb, 0);
    step();
    drive(1, 1, 1, 0, '0, 0);
    #1;
    chk("dis_new_beat0", bus, wb[31:0]);
    repeat (4) step();

    // Reset mid-word.
    drive(1, 1, 0, 1, wa, 1);
    step();
    drive(1, 1, 1, 0, '0, 0);
    step();
    drive(0, 1, 1, 0, '0, 0);
    step();
    drive(1, 1, 0, 0, '0, 0);
    #1;
    chk("rstmid_ack", ack, 0);
    chk("rstmid_ready", ready, 0);
    chk("rstmid_cnt", cnt, 0);
    chk("rstmid_idle", idle, 1);
    step();
    drive(1, 1, 1, 0, '0, 0);
    #1;
    chk("rstmid_empty", ack, 0);
    step();

    // Ready gating: word B offered while A is held must be dropped.
    wa = {$urandom, $urandom, $urandom, $urandom};
    wb = ~wa;
    drive(1, 1, 0, 1, wa, 0);
    step();
    drive(1, 1, 0, 1, wb, 1);
    repeat (2) step();
    for (int k = 0; k < 4; k++) begin
      drive(1, 1, 1, 1, wb, 1);
      #1;
      chk($sformatf("gate_beat%0d", k), bus, wa[k*32 +: 32]);
      step();
    end
    drive(1, 1, 0, 0, '0, 0);
    step();

    // Saturation of the 4-bit counter over 20 beats.
    for (int w = 0; w < 5; w++) begin
      drive(1, 1, 0, 1, {$urandom, $urandom, $urandom, $urandom}, 1);
      step();
      drive(1, 1, 1, 0, '0, 0);
      repeat (4) step();
    end
    chk("sat_cnt4", cnt4, 4'hf);

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      drive(($urandom_range(0, 63) != 0), ($urandom_range(0, 15) != 0),
            $urandom_range(0, 1), $urandom_range(0, 1),
            {$urandom, $urandom, $urandom, $urandom}, $urandom_range(0, 1));
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/edn_endpoint_resp.md
# edn_endpoint_resp

Responder side of the EDN endpoint request/acknowledge interface. It serves 32-bit entropy words to one consumer, such as the entropy requester in the AES top. It buffers one genbits word from an upstream CSRNG-style valid/ready stream and slices it into bus-width beats. Each beat is delivered exactly once, and buffered entropy is scrubbed whenever the endpoint is disabled or reset.

## Interface
Parameters:
- BusWidth, 32, endpoint data width (matches edn_pkg ENDPOINT_BUS_WIDTH)
- GenBitsWidth, 128, upstream genbits width; must be an integer multiple of BusWidth
- CntWidth, 16, width of the served-beat counter

Ports:
- Clocking: one clock; reset is synchronous and active-low.
- clk_i  in  1  clock; all logic on the rising edge.
- rst_ni  in  1  reset, synchronous, active-low.
- enable_i  in  1  endpoint enable; low flushes and scrubs the buffer.
- edn_req_i  in  1  consumer request, level.
- edn_ack_o  out  1  single-cycle acknowledge; data is valid in the same cycle.
- edn_bus_o  out  BusWidth  entropy beat, qualified by edn_ack_o.
- edn_fips_o  out  1  FIPS flag of the word the beat came from, qualified by edn_ack_o.
- genbits_valid_i  in  1  upstream word valid.
- genbits_ready_o  out  1  responder can accept a word.
- genbits_bus_i  in  GenBitsWidth  upstream entropy word.
- genbits_fips_i  in  1  upstream FIPS flag.
- beats_served_o  out  CntWidth  saturating count of acknowledged beats.
- idle_o  out  1  high when no buffered entropy is held and no request is pending.

## Operation
- NumBeats = GenBitsWidth/BusWidth.
- Beat index: a $clog2(NumBeats)-bit register, beat_q.
- States:
  - DISABLED: enable_i low.
  - EMPTY: enabled, no word held.
  - FULL: enabled, word held.
- Transitions:
  - DISABLED → EMPTY when enable_i=1.
  - EMPTY → FULL on genbits_valid_i && genbits_ready_o. This captures the word and fips flag and sets beat_q=0.
  - FULL → EMPTY when the ack for beat NumBeats-1 occurs.
  - Any state → DISABLED when enable_i=0.
- genbits_ready_o = enable_i && state==EMPTY. It is a function of registered state and enable_i only.
- edn_ack_o = edn_req_i && enable_i && state==FULL. This is combinational from the request, so a continuously held request gets one beat per cycle.
- Beat order is little-end first: beat k = word[k*BusWidth +: BusWidth].
- On each ack, beat_q increments. On the last beat it wraps to 0, the word register is zeroed, and the state goes to EMPTY.
- When edn_ack_o=0, edn_bus_o=0 and edn_fips_o=0. Entropy never appears on the bus un-acked.
- Scrubbing: entering DISABLED, or reset, zeroes the word register, the fips flag and beat_q. A partially consumed word is discarded, never resumed.
- Counter: beats_served_o increments on each ack and saturates at all-ones. Only reset clears it; disable does not.
- idle_o = (state!=FULL) && !edn_req_i.

## Timing
- Reset values:
  - edn_ack_o=0, edn_bus_o=0, edn_fips_o=0.
  - genbits_ready_o=0 (state DISABLED after reset).
  - beats_served_o=0.
  - idle_o equals !edn_req_i.
- Upstream latency: a word accepted in cycle N can first be acked in cycle N+1.
- Request latency:
  - With a held request and a FULL buffer, ack is in the same cycle.
  - From EMPTY, the earliest ack is the cycle after the upstream handshake.
- Throughput: at most NumBeats beats per NumBeats+1 cycles (one refill cycle per word).
- The consumer may hold edn_req_i across acks or drop it after any ack. Request-only cycles have no side effects.
- Simultaneous enable_i falling and req: no ack is given, and the buffer is scrubbed at that edge.
- Reset mid-word: the next cycle is DISABLED and all data is zeroed, regardless of enable_i.
- An upstream valid while not ready is ignored and not captured.

## Structure
- Shared package edn_resp_pkg holds:
  - the state enum (DISABLED, EMPTY, FULL), sparse-encoded with the Hamming-distance encodings used for other security FSMs;
  - the default BusWidth and GenBitsWidth constants.
- An invalid state encoding is treated as DISABLED, and the buffer is scrubbed.
- No sub-module. The beat slicer is an indexed part-select on the held word.

## Test plan
- Basic word: enable, push word 128'h0f0e0d0c_0b0a0908_07060504_03020100 with fips=1, hold req:
  - acks on 4 consecutive cycles with data 32'h03020100, 32'h07060504, 32'h0b0a0908, 32'h0f0e0d0c, fips=1 each;
  - then ready=1;
  - beats_served_o=4.
- Back-pressure: req held, upstream idle → no ack, bus=0, ready=1. Push a word → ack in the next cycle.
- Disable mid-word: ack 2 beats, drop enable_i for 1 cycle, re-enable:
  - no ack while the buffer is empty;
  - the next pushed word is served starting at its beat 0;
  - the remaining old beats are never seen.
- Reset mid-word: assert rst_ni=0 for 1 cycle while FULL:
  - all outputs return to their reset values;
  - beats_served_o=0;
  - the buffer is empty after reset.
- Saturation: run with CntWidth=4 for 20 beats → beats_served_o stays at 4'hf.
- Ready gating: drive genbits_valid_i while FULL with word B → B is not captured, and the beats served all come from word A.
